// File: rtl/pio_in_pkg.sv
// Shared constants for the debounced input PIO: register map and edge modes.
package pio_in_pkg;

  // Avalon register addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Edge capture modes
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_debounce_bit.sv
// One input bit: metastability synchroniser followed by a consecutive-mismatch
// debounce filter. The filtered bit only follows the synchronised input once it
// has disagreed for DEBOUNCE_CNT cycles in a row.
module pio_in_debounce_bit #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic in_async,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  // Synchroniser chain; the oldest stage is the usable sample
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_async};
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CNT == 0) begin : g_bypass
      // Filter disabled: filtered value simply tracks the synchronised input
      always_ff @(posedge clk) begin
        if (reset) filt <= 1'b0;
        else       filt <= s;
      end
    end else begin : g_filter
      // Counter value whose increment would reach DEBOUNCE_CNT
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

      logic [CNT_W-1:0] cnt;

      // Count consecutive mismatches; accept the new level on the last one
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt  <= '0;
          filt <= 1'b0;
        end else if (s == filt) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          filt <= s;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/nios_system_pio_in_irq.sv
// Avalon-MM input PIO bank with per-bit synchronise/debounce, edge capture,
// interrupt mask and a registered level IRQ.
module nios_system_pio_in_irq
  import pio_in_pkg::*;
#(
  parameter int WIDTH        = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 4,
  parameter int EDGE_TYPE    = 0,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_val;
  logic             wr_en;
  logic             rd_en;
  logic             unused_wd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_in_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .CNT_W       (CNT_W)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .in_async(in_port[i]),
      .filt    (filt[i])
    );
  end

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign w1c       = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
  // Bits above WIDTH are don't-care on writes
  assign unused_wd = ^writedata;

  // Select which transitions of the filtered value count as events
  always_comb begin
    ev = filt & ~prev;
    case (EDGE_TYPE)
      EDGE_FALL: ev = ~filt & prev;
      EDGE_ANY:  ev = filt ^ prev;
      default:   ev = filt & ~prev;
    endcase
  end

  // Read mux over the current (pre-write) register contents
  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA: rd_val[WIDTH-1:0] = filt;
      ADDR_MASK: rd_val[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_val[WIDTH-1:0] = edge_capture;
      default:   rd_val = '0;
    endcase
  end

  // Edge history and capture; a fresh event beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      prev         <= '0;
      edge_capture <= '0;
    end else begin
      prev         <= filt;
      edge_capture <= (edge_capture & ~w1c) | ev;
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk) begin
    if (reset)                                irq_mask <= '0;
    else if (wr_en && (address == ADDR_MASK)) irq_mask <= writedata[WIDTH-1:0];
  end

  // Registered read data (latency 1) and level interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (rd_en) readdata <= rd_val;
      irq <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_nios_system_pio_in_irq.sv
// Bench for the debounced input PIO: two instances (rising and any-edge) share
// stimulus; a behavioural model predicts readdata/irq every cycle.
module tb_nios_system_pio_in_irq;

  localparam int W   = 10;
  localparam int SS  = 2;
  localparam int DEB = 4;

  logic         clk        = 1'b0;
  logic         reset      = 1'b1;
  logic [1:0]   address    = 2'd0;
  logic         chipselect = 1'b0;
  logic         read       = 1'b0;
  logic         write      = 1'b0;
  logic [31:0]  writedata  = 32'd0;
  logic [W-1:0] in_port    = '0;
  logic [31:0]  readdata_r, readdata_a;
  logic         irq_r, irq_a;

  always #5 clk = ~clk;

  nios_system_pio_in_irq #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CNT(DEB), .EDGE_TYPE(0), .CNT_W(3)
  ) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_r), .irq(irq_r)
  );

  nios_system_pio_in_irq #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CNT(DEB), .EDGE_TYPE(2), .CNT_W(3)
  ) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_a), .irq(irq_a)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: input history, sliding window of synchronised samples,
  // filtered value changes when the whole window disagrees with it.
  logic [W-1:0] m_hist [SS];
  logic [W-1:0] m_swin [DEB];
  logic [W-1:0] m_filt, m_prev, m_mask;
  logic [W-1:0] m_ec [2];
  logic [31:0]  m_rd [2];
  logic         m_irq [2];
  logic [W-1:0] t_s, t_mis, t_filt, t_w1c, t_ev;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SS; k++)  m_hist[k] = '0;
      for (int k = 0; k < DEB; k++) m_swin[k] = '0;
      m_filt = '0; m_prev = '0; m_mask = '0;
      for (int j = 0; j < 2; j++) begin
        m_ec[j] = '0; m_rd[j] = '0; m_irq[j] = 1'b0;
      end
    end else begin
      t_s = m_hist[SS-1];
      for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = in_port;
      for (int k = DEB-1; k > 0; k--) m_swin[k] = m_swin[k-1];
      m_swin[0] = t_s;
      t_mis = '1;
      for (int k = 0; k < DEB; k++) t_mis &= (m_swin[k] ^ m_filt);
      t_filt = (m_filt & ~t_mis) | (t_s & t_mis);
      t_w1c = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int j = 0; j < 2; j++) begin
        t_ev = (j == 0) ? (m_filt & ~m_prev) : (m_filt ^ m_prev);
        if (chipselect && read)
          m_rd[j] = (address == 2'd0) ? 32'(m_filt) :
                    (address == 2'd2) ? 32'(m_mask) :
                    (address == 2'd3) ? 32'(m_ec[j]) : 32'd0;
        m_irq[j] = |(m_ec[j] & m_mask);
        m_ec[j]  = (m_ec[j] & ~t_w1c) | t_ev;
      end
      if (chipselect && write && address == 2'd2) m_mask = writedata[W-1:0];
      m_prev = m_filt;
      m_filt = t_filt;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("readdata_rise", readdata_r, m_rd[0]);
      cmp("readdata_any",  readdata_a, m_rd[1]);
      cmp("irq_rise", 32'(irq_r), 32'(m_irq[0]));
      cmp("irq_any",  32'(irq_a), 32'(m_irq[1]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] dr, output logic [31:0] da);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    dr = readdata_r; da = readdata_a;
  endtask

  logic [31:0] vr, va;

  initial begin
    // 1: reset with all inputs high, then latency of the filtered value
    in_port = 10'h3FF; reset = 1'b1;
    tick(2);
    chk_en = 1'b1;
    tick(1);
    cmp("rst_readdata", readdata_r, 32'd0);
    cmp("rst_irq", 32'(irq_r), 32'd0);
    reset = 1'b0; chipselect = 1'b1; read = 1'b1; address = 2'd0;
    tick(6);
    cmp("lat_data_edge6", readdata_r, 32'd0);
    tick(1);
    cmp("lat_data_edge7", readdata_r, 32'h3FF);
    chipselect = 1'b0; read = 1'b0;
    tick(3);
    bus_read(2'd3, vr, va);
    cmp("post_reset_ec_rise", vr, 32'h3FF);
    cmp("post_reset_ec_any",  va, 32'h3FF);
    bus_write(2'd3, 32'h3FF);

    // 2: short glitch is filtered out
    in_port = 10'h3FE;
    tick(12);
    bus_write(2'd3, 32'h3FF);
    bus_write(2'd2, 32'h001);
    in_port = 10'h3FF;
    tick(3);
    in_port = 10'h3FE;
    tick(12);
    bus_read(2'd0, vr, va);
    cmp("glitch_data", vr, 32'h3FE);
    bus_read(2'd3, vr, va);
    cmp("glitch_ec_rise", vr, 32'd0);
    cmp("glitch_ec_any",  va, 32'd0);
    cmp("glitch_irq", 32'(irq_r), 32'd0);

    // 3: held rising input -> capture at edge 7, irq at edge 8, W1C drops irq
    in_port = 10'h3FF;
    tick(7);
    cmp("irq_edge7", 32'(irq_r), 32'd0);
    tick(1);
    cmp("irq_edge8_rise", 32'(irq_r), 32'd1);
    cmp("irq_edge8_any",  32'(irq_a), 32'd1);
    bus_write(2'd3, 32'h001);
    cmp("irq_at_w1c", 32'(irq_r), 32'd1);
    tick(1);
    cmp("irq_after_w1c_rise", 32'(irq_r), 32'd0);
    cmp("irq_after_w1c_any",  32'(irq_a), 32'd0);

    // 4: W1C coincident with a new rising event; set wins
    in_port = 10'h3FE;
    tick(12);
    bus_write(2'd3, 32'h3FF);
    tick(2);
    cmp("pre_race_irq_rise", 32'(irq_r), 32'd0);
    cmp("pre_race_irq_any",  32'(irq_a), 32'd0);
    in_port = 10'h3FF;
    tick(6);
    chipselect = 1'b1; write = 1'b1; address = 2'd3; writedata = 32'h001;
    tick(1);
    chipselect = 1'b0; write = 1'b0; writedata = 32'd0;
    tick(1);
    cmp("race_irq_rise", 32'(irq_r), 32'd1);
    bus_read(2'd3, vr, va);
    cmp("race_ec_rise", vr, 32'h001);
    cmp("race_ec_any",  va, 32'h001);

    // 5: any-edge capture of bit 5 in both directions, mask 0
    bus_write(2'd2, 32'd0);
    bus_write(2'd3, 32'h3FF);
    tick(2);
    in_port = 10'h3DF;
    tick(10);
    bus_read(2'd3, vr, va);
    cmp("fall5_ec_rise", vr, 32'd0);
    cmp("fall5_ec_any",  va, 32'h020);
    bus_write(2'd3, 32'h3FF);
    in_port = 10'h3FF;
    tick(10);
    bus_read(2'd3, vr, va);
    cmp("rise5_ec_rise", vr, 32'h020);
    cmp("rise5_ec_any",  va, 32'h020);
    cmp("mask0_irq_any", 32'(irq_a), 32'd0);

    // 6: reset during a debounce count and during a pending read
    in_port = 10'h3FB;
    tick(12);
    in_port = 10'h3FF;
    tick(3);
    chipselect = 1'b1; read = 1'b1; address = 2'd0;
    tick(1);
    reset = 1'b1;
    tick(1);
    cmp("midrst_readdata", readdata_r, 32'd0);
    cmp("midrst_irq", 32'(irq_a), 32'd0);
    reset = 1'b0;
    tick(6);
    cmp("relat_edge6", readdata_r, 32'd0);
    tick(1);
    cmp("relat_edge7", readdata_r, 32'h3FF);
    chipselect = 1'b0; read = 1'b0;
    tick(2);

    // Randomised traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) in_port ^= W'($urandom);
      chipselect = 1'($urandom_range(0, 1));
      read       = 1'($urandom_range(0, 1));
      write      = 1'($urandom_range(0, 3) == 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom & $urandom & $urandom;
      reset      = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    chipselect = 1'b0; read = 1'b0; write = 1'b0; reset = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
